// File: rtl/alk_pkg.sv
// Shared encodings for the ALK ALU step sequencer: ALU micro-op codes,
// operation selects and the sequencer state encoding.
package alk_pkg;

  typedef enum logic [3:0] {
    SUB     = 4'b0000,
    SUB_SL  = 4'b0011,
    ADD     = 4'b0100,
    ADD_SL  = 4'b0111,
    ADD_SR  = 4'b0110,
    PASS_SR = 4'b1010
  } alu_code_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIV  = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/alk_step_seq.sv
// Multi-cycle step sequencer for the ALK ALU. While busy it overrides the
// microsequencer ALU field with shift-and-add multiply or non-restoring
// divide micro-ops, one per non-stalled cycle.
module alk_step_seq
  import alk_pkg::*;
#(
  parameter int MAX_STEPS = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk_h,
  input  logic             reset_l,
  input  logic             start_h,
  input  logic [1:0]       op_h,
  input  logic [CNT_W-1:0] count_h,
  input  logic             mul_bit_h,
  input  logic             sign_h,
  input  logic             stall_l,
  input  logic             abort_h,
  output logic [3:0]       alu_h,
  output logic             long_lit_l,
  output logic             alu_valid_h,
  output logic             q_bit_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [CNT_W-1:0] step_h
);

  state_t           state_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] step_q;
  logic             first_q;
  logic [CNT_W-1:0] load_cnt;
  logic             legal_op;
  alu_code_t        alu_code;

  // Requests beyond MAX_STEPS are clamped rather than truncated.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    if (32'(c) > 32'(MAX_STEPS))
      return CNT_W'(MAX_STEPS);
    else
      return c;
  endfunction

  assign load_cnt = sat_count(count_h);
  assign legal_op = (op_h == OP_MUL) || (op_h == OP_DIV);

  // Sequencer FSM, step counter and latched operation.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      step_q  <= '0;
      first_q <= 1'b0;
    end else if (abort_h) begin
      // Abort wins over stall and over a coincident start; no done pulse.
      state_q <= ST_IDLE;
      step_q  <= '0;
      first_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stall_l && start_h && legal_op) begin
            op_q    <= op_h;
            step_q  <= load_cnt;
            first_q <= 1'b1;
            state_q <= (load_cnt == '0) ? ST_DONE : ST_STEP;
          end
        end
        ST_STEP: begin
          if (stall_l) begin
            first_q <= 1'b0;
            if (step_q != '0)
              step_q <= step_q - CNT_W'(1);
            if (step_q <= CNT_W'(1))
              // A negative final remainder needs one restoring add.
              state_q <= ((op_q == OP_DIV) && sign_h) ? ST_FIX : ST_DONE;
          end
        end
        ST_FIX: begin
          if (stall_l)
            state_q <= ST_DONE;
        end
        ST_DONE: begin
          // The completion pulse is never stretched by a stall.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Micro-op code mux; follows live sign/multiplier bits even when stalled.
  always_comb begin
    alu_code    = ADD;
    alu_valid_h = 1'b0;
    q_bit_h     = 1'b0;
    case (state_q)
      ST_STEP: begin
        alu_valid_h = 1'b1;
        if (op_q == OP_MUL) begin
          alu_code = mul_bit_h ? ADD_SR : PASS_SR;
        end else if (first_q) begin
          alu_code = SUB_SL;
        end else begin
          alu_code = sign_h ? ADD_SL : SUB_SL;
          q_bit_h  = ~sign_h;
        end
      end
      ST_FIX: begin
        alu_code    = ADD;
        alu_valid_h = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_h      = alu_code;
  assign long_lit_l = 1'b1;
  assign busy_h     = (state_q != ST_IDLE);
  assign done_h     = (state_q == ST_DONE);
  assign step_h     = step_q;

endmodule

// File: tb/tb_alk_step_seq.sv
// Scoreboard bench for alk_step_seq: each driven cycle pushes its expected
// outputs; a monitor pops and compares them mid-cycle.
module tb_alk_step_seq;

  typedef struct packed {
    int         tid;
    int         cyc;
    logic [3:0] alu;
    logic       valid;
    logic       q;
    logic       busy;
    logic       done;
    logic [5:0] step;
  } exp_t;

  logic       clk;
  logic       reset_l;
  logic       start_h;
  logic [1:0] op_h;
  logic [5:0] count_h;
  logic       mul_bit_h;
  logic       sign_h;
  logic       stall_l;
  logic       abort_h;
  logic [3:0] alu_h;
  logic       long_lit_l;
  logic       alu_valid_h;
  logic       q_bit_h;
  logic       busy_h;
  logic       done_h;
  logic [5:0] step_h;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tid      = 0;
  int   cyc      = 0;

  alk_step_seq #(.MAX_STEPS(32), .CNT_W(6)) dut (
    .clk_h      (clk),
    .reset_l    (reset_l),
    .start_h    (start_h),
    .op_h       (op_h),
    .count_h    (count_h),
    .mul_bit_h  (mul_bit_h),
    .sign_h     (sign_h),
    .stall_l    (stall_l),
    .abort_h    (abort_h),
    .alu_h      (alu_h),
    .long_lit_l (long_lit_l),
    .alu_valid_h(alu_valid_h),
    .q_bit_h    (q_bit_h),
    .busy_h     (busy_h),
    .done_h     (done_h),
    .step_h     (step_h)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string pfx, input exp_t e);
    check({pfx, ".alu"},   32'(alu_h),       32'(e.alu));
    check({pfx, ".valid"}, 32'(alu_valid_h), 32'(e.valid));
    check({pfx, ".qbit"},  32'(q_bit_h),     32'(e.q));
    check({pfx, ".busy"},  32'(busy_h),      32'(e.busy));
    check({pfx, ".done"},  32'(done_h),      32'(e.done));
    check({pfx, ".step"},  32'(step_h),      32'(e.step));
    check({pfx, ".lit"},   32'(long_lit_l),  32'd1);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what must appear.
  task automatic drive(input logic st, input logic [1:0] op, input logic [5:0] cnt,
                       input logic mb, input logic sg, input logic stl, input logic ab,
                       input logic [3:0] ealu, input logic ev, input logic eq,
                       input logic ebusy, input logic edone, input logic [5:0] estep);
    exp_t e;
    @(negedge clk);
    start_h   = st;
    op_h      = op;
    count_h   = cnt;
    mul_bit_h = mb;
    sign_h    = sg;
    stall_l   = stl;
    abort_h   = ab;
    e.tid = tid; e.cyc = cyc;
    e.alu = ealu; e.valid = ev; e.q = eq;
    e.busy = ebusy; e.done = edone; e.step = estep;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 2'b00, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic new_test(input int t);
    tid = t;
    cyc = 0;
  endtask

  // Monitor: compare queued expectations well after the inputs settle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_outputs($sformatf("t%0d.c%0d", e.tid, e.cyc), e);
    end
  end

  initial begin
    exp_t rst_e;
    reset_l   = 1'b0;
    start_h   = 1'b0;
    op_h      = 2'b00;
    count_h   = 6'd0;
    mul_bit_h = 1'b0;
    sign_h    = 1'b0;
    stall_l   = 1'b1;
    abort_h   = 1'b0;
    rst_e = '{tid: 0, cyc: 0, alu: 4'b0100, valid: 1'b0, q: 1'b0,
              busy: 1'b0, done: 1'b0, step: 6'd0};

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    check_outputs("reset", rst_e);
    @(negedge clk);
    reset_l = 1'b1;

    // MUL count 4, multiplier bits 1,0,1,1
    new_test(1);
    drive(1, 2'b01, 6'd4, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 1, 0, 1, 0, 4'b0110, 1, 0, 1, 0, 6'd4);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b1010, 1, 0, 1, 0, 6'd3);
    drive(0, 2'b00, 6'd0, 1, 0, 1, 0, 4'b0110, 1, 0, 1, 0, 6'd2);
    drive(0, 2'b00, 6'd0, 1, 0, 1, 0, 4'b0110, 1, 0, 1, 0, 6'd1);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 0, 0, 1, 1, 6'd0);
    idle_cycle();

    // DIV count 3, ending negative so a FIX step follows
    new_test(2);
    drive(1, 2'b10, 6'd3, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0011, 1, 0, 1, 0, 6'd3);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0011, 1, 1, 1, 0, 6'd2);
    drive(0, 2'b00, 6'd0, 0, 1, 1, 0, 4'b0111, 1, 0, 1, 0, 6'd1);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 1, 0, 1, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 0, 0, 1, 1, 6'd0);
    idle_cycle();

    // MUL count 3 with a two-cycle stall on step 2
    new_test(3);
    drive(1, 2'b01, 6'd3, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b1010, 1, 0, 1, 0, 6'd3);
    drive(0, 2'b00, 6'd0, 1, 0, 0, 0, 4'b0110, 1, 0, 1, 0, 6'd2);
    drive(0, 2'b00, 6'd0, 0, 0, 0, 0, 4'b1010, 1, 0, 1, 0, 6'd2);
    drive(0, 2'b00, 6'd0, 1, 0, 1, 0, 4'b0110, 1, 0, 1, 0, 6'd2);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b1010, 1, 0, 1, 0, 6'd1);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 0, 0, 1, 1, 6'd0);
    idle_cycle();

    // Zero count goes straight to DONE; illegal op never starts
    new_test(4);
    drive(1, 2'b01, 6'd0, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 0, 0, 1, 1, 6'd0);
    drive(1, 2'b11, 6'd5, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    idle_cycle();

    // Count 40 saturates to 32, then abort returns to IDLE without done
    new_test(5);
    drive(1, 2'b01, 6'd40, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0,  0, 0, 1, 1, 4'b1010, 1, 0, 1, 0, 6'd32);
    idle_cycle();

    // DIV: start while busy ignored, abort (with start) on step 2
    new_test(6);
    drive(1, 2'b10, 6'd5, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(1, 2'b01, 6'd2, 0, 0, 1, 0, 4'b0011, 1, 0, 1, 0, 6'd5);
    drive(1, 2'b01, 6'd2, 0, 1, 1, 1, 4'b0111, 1, 0, 1, 0, 6'd4);
    idle_cycle();
    idle_cycle();

    // DIV count 1 into FIX, then asynchronous reset mid-FIX
    new_test(7);
    drive(1, 2'b10, 6'd1, 0, 0, 1, 0, 4'b0100, 0, 0, 0, 0, 6'd0);
    drive(0, 2'b00, 6'd0, 0, 1, 1, 0, 4'b0011, 1, 0, 1, 0, 6'd1);
    drive(0, 2'b00, 6'd0, 0, 0, 1, 0, 4'b0100, 1, 0, 1, 0, 6'd0);
    #4;
    reset_l = 1'b0;
    #1;
    check_outputs("t7.async_reset", rst_e);
    @(negedge clk);
    reset_l = 1'b1;
    idle_cycle();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #5;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
